// File: rtl/axis_pkg.sv
// Shared types and elaboration helpers for the AXI-Stream packet master.
package axis_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned MIN_DEPTH = 2;

    // FIFO depths must be powers of two so the pointer wrap bit gives full/empty.
    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
    endfunction

    // Packed width of a {len, id} descriptor.
    function automatic int unsigned desc_bits(input int unsigned len_w, input int unsigned id_w);
        return len_w + id_w;
    endfunction

endpackage

// File: rtl/axis_fifo_sync.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
module axis_fifo_sync #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // NOTE: storage is not reset; the head is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/axis_m_pkt.sv
// AXI-Stream master framing buffered data into back-to-back packets from a descriptor queue.
// Defining AXIS_M_PKT_CNT_EN adds the pkt_cnt completed-packet counter output.
module axis_m_pkt
    import axis_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LEN_WIDTH  = 10,
    parameter int unsigned DATA_DEPTH = 8,
    parameter int unsigned CFG_DEPTH  = 4,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 ready,
    input  logic                 cfg_valid,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic [ID_WIDTH-1:0]  cfg_id,
    output logic                 cfg_ready,
    output logic [WIDTH-1:0]     m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [ID_WIDTH-1:0]  m_axis_tid,
    output logic                 busy,
    output logic                 pkt_done
`ifdef AXIS_M_PKT_CNT_EN
    ,
    output logic [31:0]          pkt_cnt
`endif
);

    typedef struct packed {
        logic [LEN_WIDTH-1:0] len;
        logic [ID_WIDTH-1:0]  id;
    } desc_t;

    localparam int unsigned          DESC_W  = desc_bits(LEN_WIDTH, ID_WIDTH);
    localparam logic [LEN_WIDTH-1:0] CNT_ONE = LEN_WIDTH'(1);

    if (!depth_ok(DATA_DEPTH) || !depth_ok(CFG_DEPTH)) begin : g_bad_depth
        $error("axis_m_pkt: DATA_DEPTH and CFG_DEPTH must be powers of two >= 2");
    end

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [ID_WIDTH-1:0]  id_q, id_d;
    logic                 done_q;

    logic  data_full, data_empty;
    logic  cfg_full, cfg_empty;
    logic  cfg_pop;
    logic  beat;
    desc_t cfg_wdesc;
    desc_t cfg_head;

    assign cfg_wdesc = '{len: cfg_len, id: cfg_id};

    axis_fifo_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DATA_DEPTH)
    ) u_data_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (valid_in),
        .wdata_i (data_in),
        .pop_i   (beat),
        .rdata_o (m_axis_tdata),
        .full_o  (data_full),
        .empty_o (data_empty)
    );

    axis_fifo_sync #(
        .WIDTH (DESC_W),
        .DEPTH (CFG_DEPTH)
    ) u_cfg_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cfg_valid),
        .wdata_i (cfg_wdesc),
        .pop_i   (cfg_pop),
        .rdata_o (cfg_head),
        .full_o  (cfg_full),
        .empty_o (cfg_empty)
    );

    assign ready         = !data_full;
    assign cfg_ready     = !cfg_full;
    assign busy          = (state_q == ST_RUN);
    assign m_axis_tvalid = busy && !data_empty;
    assign m_axis_tlast  = busy && (count_q == len_q);
    assign m_axis_tid    = id_q;
    assign beat          = m_axis_tvalid && m_axis_tready;
    assign pkt_done      = done_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        id_d    = id_q;
        cfg_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!cfg_empty) begin
                    cfg_pop = 1'b1;
                    len_d   = cfg_head.len;
                    id_d    = cfg_head.id;
                    count_d = CNT_ONE;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat && m_axis_tlast) begin
                    count_d = CNT_ONE;
                    // Chain straight into the next queued packet with no idle cycle.
                    if (!cfg_empty) begin
                        cfg_pop = 1'b1;
                        len_d   = cfg_head.len;
                        id_d    = cfg_head.id;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (beat) begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= CNT_ONE;
            len_q   <= '0;
            id_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            id_q    <= id_d;
            done_q  <= beat && m_axis_tlast;
        end
    end

`ifdef AXIS_M_PKT_CNT_EN
    logic [31:0] pkt_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pkt_cnt_q <= '0;
        else if (done_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_m_pkt.sv
// Bench for axis_m_pkt: directed packet scenarios plus randomized traffic against a queue model.
module tb_axis_m_pkt;

    localparam int WIDTH      = 32;
    localparam int LEN_WIDTH  = 10;
    localparam int DATA_DEPTH = 8;
    localparam int CFG_DEPTH  = 4;
    localparam int ID_WIDTH   = 4;
    localparam int L3_BEATS   = 1 << 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 valid_in = 1'b0;
    logic [WIDTH-1:0]     data_in = '0;
    logic                 ready;
    logic                 cfg_valid = 1'b0;
    logic [LEN_WIDTH-1:0] cfg_len = '0;
    logic [ID_WIDTH-1:0]  cfg_id = '0;
    logic                 cfg_ready;
    logic [WIDTH-1:0]     tdata;
    logic                 tvalid;
    logic                 tready = 1'b0;
    logic                 tlast;
    logic [ID_WIDTH-1:0]  tid;
    logic                 busy;
    logic                 pkt_done;

    logic                 s3_valid_in = 1'b0;
    logic [WIDTH-1:0]     s3_data_in = '0;
    logic                 s3_ready;
    logic                 s3_cfg_valid = 1'b0;
    logic [2:0]           s3_cfg_len = '0;
    logic [ID_WIDTH-1:0]  s3_cfg_id = '0;
    logic                 s3_cfg_ready;
    logic [WIDTH-1:0]     s3_tdata;
    logic                 s3_tvalid;
    logic                 s3_tready = 1'b0;
    logic                 s3_tlast;
    logic [ID_WIDTH-1:0]  s3_tid;
    logic                 s3_busy;
    logic                 s3_pkt_done;
`ifdef AXIS_M_PKT_CNT_EN
    logic [31:0]          pkt_cnt;
    logic [31:0]          s3_pkt_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axis_m_pkt #(
        .WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH), .DATA_DEPTH(DATA_DEPTH),
        .CFG_DEPTH(CFG_DEPTH), .ID_WIDTH(ID_WIDTH)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .ready(ready),
        .cfg_valid(cfg_valid), .cfg_len(cfg_len), .cfg_id(cfg_id), .cfg_ready(cfg_ready),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .m_axis_tid(tid), .busy(busy), .pkt_done(pkt_done)
`ifdef AXIS_M_PKT_CNT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    axis_m_pkt #(
        .WIDTH(WIDTH), .LEN_WIDTH(3), .DATA_DEPTH(DATA_DEPTH),
        .CFG_DEPTH(CFG_DEPTH), .ID_WIDTH(ID_WIDTH)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .valid_in(s3_valid_in), .data_in(s3_data_in), .ready(s3_ready),
        .cfg_valid(s3_cfg_valid), .cfg_len(s3_cfg_len), .cfg_id(s3_cfg_id), .cfg_ready(s3_cfg_ready),
        .m_axis_tdata(s3_tdata), .m_axis_tvalid(s3_tvalid), .m_axis_tready(s3_tready),
        .m_axis_tlast(s3_tlast), .m_axis_tid(s3_tid), .busy(s3_busy), .pkt_done(s3_pkt_done)
`ifdef AXIS_M_PKT_CNT_EN
        , .pkt_cnt(s3_pkt_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: words held in the buffer, queued descriptors, and the packet in flight.
    logic [WIDTH-1:0] m_data[$];
    int               m_len[$];
    int               m_id[$];
    int               m_rem = 0;
    int               m_cur_id = 0;
    int               acc_words = 0;
    bit               done_exp = 1'b0;

    function automatic bit model_idle();
        return (m_rem == 0) && (m_len.size() == 0) && (m_data.size() == 0);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_data.delete();
            m_len.delete();
            m_id.delete();
            m_rem    = 0;
            done_exp = 1'b0;
        end else begin
            bit push_ok;
            check("pkt_done_pulse", pkt_done, done_exp);
            check("ready_vs_fill", ready, m_data.size() < DATA_DEPTH);
            push_ok  = valid_in && (m_data.size() < DATA_DEPTH);
            done_exp = 1'b0;
            if (tvalid && tready) begin
                if (m_rem == 0) begin
                    if (m_len.size() == 0) begin
                        check("beat_without_descriptor", 1, 0);
                    end else begin
                        m_rem    = (m_len[0] == 0) ? (1 << LEN_WIDTH) : m_len[0];
                        m_cur_id = m_id[0];
                        void'(m_len.pop_front());
                        void'(m_id.pop_front());
                    end
                end
                if (m_data.size() == 0) begin
                    check("beat_without_data", 1, 0);
                end else begin
                    check("beat_data", tdata, m_data.pop_front());
                    check("beat_id", tid, m_cur_id);
                    check("beat_last", tlast, m_rem == 1);
                    done_exp = (m_rem == 1);
                    if (m_rem > 0) m_rem--;
                end
            end
            if (push_ok) begin
                m_data.push_back(data_in);
                acc_words++;
            end
            if (cfg_valid) begin
                m_len.push_back(int'(cfg_len));
                m_id.push_back(int'(cfg_id));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int target;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tid", tid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_ready", ready, 1);
        check("rst_cfg_ready", cfg_ready, 1);
        rst_n = 1'b1;
        tick();

        // Single packet len=4 id=3
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; data_in = 32'hA0 + i;
            cfg_valid = (i == 0); cfg_len = 10'd4; cfg_id = 4'd3;
            tick();
        end
        valid_in = 1'b0; cfg_valid = 1'b0;
        check("t1_busy", busy, 1);
        tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t1_tvalid", tvalid, 1);
            check("t1_tdata", tdata, 32'hA0 + i);
            check("t1_tlast", tlast, i == 3);
            check("t1_tid", tid, 3);
            tick();
        end
        check("t1_pkt_done", pkt_done, 1);
        check("t1_busy_fall", busy, 0);
        tick();
        check("t1_pkt_done_clear", pkt_done, 0);
        tready = 1'b0;

        // Two queued packets run back-to-back
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1; data_in = 32'hC0 + i;
            cfg_valid = (i < 2);
            cfg_len = (i == 0) ? 10'd2 : 10'd3;
            cfg_id  = (i == 0) ? 4'd1 : 4'd2;
            tick();
        end
        valid_in = 1'b0; cfg_valid = 1'b0;
        tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t2_tvalid_no_gap", tvalid, 1);
            check("t2_tdata", tdata, 32'hC0 + i);
            check("t2_tlast", tlast, (i == 1) || (i == 4));
            check("t2_tid", tid, (i < 2) ? 1 : 2);
            tick();
        end
        check("t2_busy_fall", busy, 0);
        tready = 1'b0;

        // Descriptor with no data, then one late word
        cfg_valid = 1'b1; cfg_len = 10'd1; cfg_id = 4'd9;
        tick();
        cfg_valid = 1'b0;
        tick();
        check("t3_busy", busy, 1);
        check("t3_tvalid_empty", tvalid, 0);
        valid_in = 1'b1; data_in = 32'h55;
        tick();
        valid_in = 1'b0;
        check("t3_tvalid_next", tvalid, 1);
        check("t3_tdata", tdata, 32'h55);
        repeat (2) tick();
        check("t3_tvalid_held", tvalid, 1);
        check("t3_tdata_held", tdata, 32'h55);
        check("t3_tlast", tlast, 1);
        tready = 1'b1;
        tick();
        check("t3_tvalid_after", tvalid, 0);
        check("t3_busy_after", busy, 0);
        tready = 1'b0;

        // Fill the data buffer with tready low
        for (int i = 0; i < DATA_DEPTH; i++) begin
            valid_in = 1'b1; data_in = 32'hB0 + i;
            cfg_valid = (i == 0); cfg_len = 10'd8; cfg_id = 4'd4;
            tick();
            check("t4_ready_fill", ready, i != DATA_DEPTH - 1);
        end
        cfg_valid = 1'b0;
        data_in = 32'hDEAD;
        tick();
        valid_in = 1'b0;
        check("t4_ready_full", ready, 0);
        tready = 1'b1;
        for (int i = 0; i < DATA_DEPTH; i++) begin
            check("t4_tdata", tdata, 32'hB0 + i);
            check("t4_tlast", tlast, i == DATA_DEPTH - 1);
            tick();
            if (i == 0) check("t4_ready_reassert", ready, 1);
        end
        check("t4_ninth_dropped", tvalid, 0);
        tready = 1'b0;

        // LEN_WIDTH=3 instance, cfg_len=0 means 8 beats
        for (int i = 0; i < L3_BEATS; i++) begin
            s3_valid_in = 1'b1; s3_data_in = 32'hD0 + i;
            s3_cfg_valid = (i == 0); s3_cfg_len = 3'd0; s3_cfg_id = 4'd5;
            tick();
        end
        s3_valid_in = 1'b0; s3_cfg_valid = 1'b0;
        s3_tready = 1'b1;
        for (int i = 0; i < L3_BEATS; i++) begin
            check("t5_tvalid", s3_tvalid, 1);
            check("t5_tdata", s3_tdata, 32'hD0 + i);
            check("t5_tlast", s3_tlast, i == L3_BEATS - 1);
            check("t5_tid", s3_tid, 5);
            tick();
        end
        check("t5_pkt_done", s3_pkt_done, 1);
        check("t5_busy_fall", s3_busy, 0);
        s3_tready = 1'b0;

        // Reset during beat 2 of a 4-beat packet
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; data_in = 32'hE0 + i;
            cfg_valid = (i == 0); cfg_len = 10'd4; cfg_id = 4'd7;
            tick();
        end
        valid_in = 1'b0; cfg_valid = 1'b0;
        tready = 1'b1;
        tick();
        check("t6_beat2_data", tdata, 32'hE1);
        rst_n = 1'b0;
        tready = 1'b0;
        #1;
        check("t6_rst_tvalid", tvalid, 0);
        check("t6_rst_tlast", tlast, 0);
        check("t6_rst_tid", tid, 0);
        check("t6_rst_tdata", tdata, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", ready, 1);
        check("t6_rst_cfg_ready", cfg_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        valid_in = 1'b1; data_in = 32'h77;
        cfg_valid = 1'b1; cfg_len = 10'd1; cfg_id = 4'd2;
        tready = 1'b1;
        tick();
        valid_in = 1'b0; cfg_valid = 1'b0;
        k = 0;
        while (tvalid !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check("t6_post_tvalid", tvalid, 1);
        check("t6_post_tdata", tdata, 32'h77);
        check("t6_post_tlast", tlast, 1);
        check("t6_post_tid", tid, 2);
        tick();
        check("t6_post_pkt_done", pkt_done, 1);
        tick();
`ifdef AXIS_M_PKT_CNT_EN
        check("t6_pkt_cnt", pkt_cnt, 1);
`endif
        tready = 1'b0;

        // Randomized traffic: rounds of four descriptors with random data and back-pressure
        for (int r = 0; r < 3; r++) begin
            target = acc_words;
            for (int d = 0; d < CFG_DEPTH; d++) begin
                cfg_valid = 1'b1;
                cfg_len   = LEN_WIDTH'($urandom_range(1, 5));
                cfg_id    = ID_WIDTH'($urandom);
                target   += int'(cfg_len);
                valid_in  = 1'($urandom_range(0, 1));
                data_in   = $urandom;
                tready    = 1'($urandom_range(0, 1));
                tick();
            end
            cfg_valid = 1'b0;
            for (int c = 0; c < 400 && acc_words < target; c++) begin
                valid_in = 1'($urandom_range(0, 1));
                data_in  = $urandom;
                tready   = 1'($urandom_range(0, 1));
                tick();
            end
            valid_in = 1'b0;
            check("rand_words_accepted", acc_words, target);
            for (int c = 0; c < 400 && !model_idle(); c++) begin
                tready = 1'($urandom_range(0, 1));
                tick();
            end
            check("rand_drained", model_idle(), 1);
            tready = 1'b0;
            check("rand_busy_idle", busy, 0);
            check("rand_tvalid_idle", tvalid, 0);
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_m_pkt.md
# axis_m_pkt

Parametrised AXI-Stream master with a configurable data buffer depth and a queue of packet descriptors. Each descriptor carries a beat count and a stream ID; the block frames buffered data into back-to-back packets, asserting TLAST on the final beat with no bubble between packets. It sits between a datapath producer and any AXI-Stream slave in the interconnect model, and replaces the single-descriptor master.

## Interface
- WIDTH, 32, data width in bits
- LEN_WIDTH, 10, beat-count width; cfg_len 0 encodes 2^LEN_WIDTH beats
- DATA_DEPTH, 8, data FIFO entries (power of 2, ≥2)
- CFG_DEPTH, 4, descriptor FIFO entries (power of 2, ≥2)
- ID_WIDTH, 4, stream ID width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_in  in  1  producer data valid
- data_in  in  WIDTH  producer data
- ready  out  1  data FIFO not full
- cfg_valid  in  1  descriptor valid
- cfg_len  in  LEN_WIDTH  packet beat count
- cfg_id  in  ID_WIDTH  packet stream ID
- cfg_ready  out  1  descriptor FIFO not full
- m_axis_tdata  out  WIDTH  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  slave ready
- m_axis_tlast  out  1  last beat of packet
- m_axis_tid  out  ID_WIDTH  ID of current packet
- busy  out  1  state is RUN
- pkt_done  out  1  one-cycle pulse, registered, cycle after a TLAST beat is accepted

## Operation
- Data push: valid_in && ready. Descriptor push: cfg_valid && cfg_ready. Input when not ready is dropped, not stored.
- ready = ~data_full; cfg_ready = ~cfg_full. Neither considers a same-cycle pop.
- States: IDLE, RUN.
  - IDLE: if descriptor FIFO is non-empty, pop it, latch len/id, count := 1, go to RUN.
  - RUN: beat = tvalid && tready; count += 1 on each beat.
- m_axis_tvalid = RUN && ~data_empty. m_axis_tdata is the data FIFO head (first-word fall-through).
- m_axis_tlast = RUN && count == len_store. The count is LEN_WIDTH bits and wraps, so len 0 terminates at beat 2^LEN_WIDTH.
- TLAST beat handling:
  - If the descriptor FIFO is non-empty, pop and latch the next descriptor, count := 1, and stay in RUN (zero-bubble).
  - Otherwise go to IDLE.
- m_axis_tid = id_store. It is held stable for the whole packet.
- tvalid is not retracted once asserted until accepted, because data only leaves on a beat.
- Reset mid-packet: both FIFOs empty, state IDLE, count 1, stores 0. Partially sent packets are abandoned.

## Timing
- Reset values:
  - m_axis_tvalid 0, m_axis_tlast 0, m_axis_tid 0, m_axis_tdata 0.
  - busy 0, pkt_done 0.
  - ready 1, cfg_ready 1.
- Data latency: a push in cycle N can appear on tdata/tvalid in cycle N+1.
- Descriptor latency:
  - Push in cycle N (block IDLE): pop at N+1, RUN at N+2.
  - First tvalid no earlier than N+2.
- Packets run back-to-back: the first beat of the next packet may be accepted the cycle after the TLAST beat.
- Full FIFO: ready deasserts the cycle after the push that fills it, and reasserts the cycle after a pop.

## Configuration
- AXIS_M_PKT_CNT_EN defined:
  - Adds output pkt_cnt [31:0], a count of completed packets.
  - It increments with pkt_done, wraps at 2^32, and resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package axis_pkg holds:
  - the state enum (IDLE, RUN);
  - the descriptor struct {len, id} as a parametrised-width typedef helper;
  - the power-of-2 depth check constant.
- One sub-module: axis_fifo_sync. It is a parametrised synchronous FWFT FIFO (WIDTH, DEPTH) with full/empty flags, instantiated twice: data, and descriptor (packed {len, id}).
- Counters, FSM and pkt_done register live in the top.

## Test plan
- Descriptor len=4 id=3, push 4 words 0xA0..0xA3, tready=1:
  - four beats with tid=3;
  - tlast only on 0xA3;
  - pkt_done pulses next cycle;
  - busy falls.
- Two descriptors (len=2 id=1, len=3 id=2) queued, 5 words present, tready=1:
  - 5 consecutive beats with no gap;
  - tlast on beats 2 and 5;
  - tid changes 1→2 on beat 3.
- Descriptor only, no data:
  - tvalid=0 while busy=1;
  - push 0x55 → tvalid next cycle;
  - tvalid held until tready.
- Fill 8 words with tready=0:
  - ready=0 after the 8th push, and a 9th valid_in is dropped;
  - then tready=1 → exactly 8 words out in order.
- LEN_WIDTH=3, cfg_len=0: tlast on beat 8.
- Reset asserted mid-packet (beat 2 of 4):
  - outputs return to reset values;
  - post-reset len=1 packet transfers correctly;
  - with AXIS_M_PKT_CNT_EN, pkt_cnt=1.
